pool1_window_streamer: RTL

//  Downstream neighbour of the 2x2/stride-2 32-ch max-pool stage (13x13x32 int8 map, 5408 bytes).
//  On start, it reads the pooled map through the pool's read_addr/read_data port.
//  It emits every 3x3 valid-padding window (11x11 positions x 32 ch) as a byte stream with

---
 rtl/pool1_window_streamer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/pool1_window_streamer.sv
`default_nettype none
// ============================================================================
// Module      : pool1_window_streamer
// Description : Reads the pooled int8 feature map (channel-major) and streams
//               every KxK valid-padding window as bytes with valid/ready and
//               win/pos/frame framing flags, feeding the conv2 MAC array.
// Revision    : 1.0 - initial release
// ============================================================================
module pool1_window_streamer #(
    parameter int IMG_W = 13,
    parameter int IMG_H = 13,
    parameter int CH    = 32,
    parameter int K     = 3,
    parameter int DW    = 8,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_win_last,
    output logic          out_pos_last,
    output logic          out_frame_last
);

    localparam int c_OUT_W = IMG_W - K + 1;
    localparam int c_OUT_H = IMG_H - K + 1;
    localparam int c_PLANE = IMG_W * IMG_H;
    localparam int c_KW    = $clog2(K + 1);
    localparam int c_CW    = $clog2(CH + 1);
    localparam int c_XW    = $clog2(c_OUT_W + 1);
    localparam int c_YW    = $clog2(c_OUT_H + 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    logic [c_KW-1:0] r_kx;
    logic [c_KW-1:0] r_ky;
    logic [c_CW-1:0] r_c;
    logic [c_XW-1:0] r_ox;
    logic [c_YW-1:0] r_oy;

    logic            w_kx_end;
    logic            w_ky_end;
    logic            w_c_end;
    logic            w_ox_end;
    logic            w_oy_end;
    logic [2:0]      w_flags;   // {frame_last, pos_last, win_last}
    logic [AW-1:0]   w_addr;

    logic [AW-1:0]   r_mem_addr;
    logic            r_pend;    // read issued last cycle, data arrives this cycle
    logic [2:0]      r_pend_flags;

    logic [DW-1:0]   r_fifo_data  [2];
    logic [2:0]      r_fifo_flags [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic [2:0]      w_commit;

    // Terminal-count detection for the window/position counters
    assign w_kx_end = (r_kx == c_KW'(K - 1));
    assign w_ky_end = (r_ky == c_KW'(K - 1));
    assign w_c_end  = (r_c  == c_CW'(CH - 1));
    assign w_ox_end = (r_ox == c_XW'(c_OUT_W - 1));
    assign w_oy_end = (r_oy == c_YW'(c_OUT_H - 1));

    assign w_flags[0] = w_kx_end & w_ky_end;
    assign w_flags[1] = w_flags[0] & w_c_end;
    assign w_flags[2] = w_flags[1] & w_ox_end & w_oy_end;

    // Channel-major address of the current window tap
    assign w_addr = AW'(r_c) * AW'(c_PLANE)
                  + (AW'(r_oy) + AW'(r_ky)) * AW'(IMG_W)
                  + AW'(r_ox) + AW'(r_kx);

    // Issue only while the bytes already committed (queued + in flight,
    // minus the one leaving now) leave room in the 2-entry FIFO.
    assign w_pop    = out_valid & out_ready;
    assign w_push   = r_pend;
    assign w_commit = 3'(r_count) + 3'(r_pend) - 3'(w_pop);
    assign w_issue  = (r_state == c_S_RUN) && (w_commit < 3'd2);

    assign mem_addr       = r_mem_addr;
    assign out_valid      = (r_count != 2'd0);
    assign out_data       = r_fifo_data[r_rd_ptr];
    assign out_win_last   = r_fifo_flags[r_rd_ptr][0];
    assign out_pos_last   = r_fifo_flags[r_rd_ptr][1];
    assign out_frame_last = r_fifo_flags[r_rd_ptr][2];
    assign busy           = (r_state != c_S_IDLE);
    assign done           = (r_state == c_S_DONE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DRAIN ends the cycle the final byte leaves the FIFO
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (start) w_state_nxt = c_S_RUN;
            c_S_RUN:   if (w_issue && w_flags[2]) w_state_nxt = c_S_DRAIN;
            c_S_DRAIN: if (!r_pend && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)))
                           w_state_nxt = c_S_DONE;
            c_S_DONE:  w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // Window counters: kx fastest, then ky, c, ox, oy; cleared on a new frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kx <= '0;
            r_ky <= '0;
            r_c  <= '0;
            r_ox <= '0;
            r_oy <= '0;
        end else if ((r_state == c_S_IDLE) && start) begin
            r_kx <= '0;
            r_ky <= '0;
            r_c  <= '0;
            r_ox <= '0;
            r_oy <= '0;
        end else if (w_issue) begin
            if (!w_kx_end) begin
                r_kx <= r_kx + 1'b1;
            end else begin
                r_kx <= '0;
                if (!w_ky_end) begin
                    r_ky <= r_ky + 1'b1;
                end else begin
                    r_ky <= '0;
                    if (!w_c_end) begin
                        r_c <= r_c + 1'b1;
                    end else begin
                        r_c <= '0;
                        if (!w_ox_end) begin
                            r_ox <= r_ox + 1'b1;
                        end else begin
                            r_ox <= '0;
                            r_oy <= w_oy_end ? '0 : r_oy + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Read issue: address and flags launched together, address held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_addr   <= '0;
            r_pend       <= 1'b0;
            r_pend_flags <= '0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_mem_addr   <= w_addr;
                r_pend_flags <= w_flags;
            end
        end
    end

    // Output FIFO: captures returning read data with its flags, pops on handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_flags[0] <= '0;
            r_fifo_flags[1] <= '0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr]  <= mem_data;
                r_fifo_flags[r_wr_ptr] <= r_pend_flags;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire
